// File: rtl/stream_demux_1x2.sv
// ---------------------------------------------------------------------------
// stream_demux_1x2
//
// Splits one valid/ready stream into two output streams. The side-band select
// bit travels with each beat and chooses its destination. Each output has
// its own DEPTH-entry first-word-fall-through FIFO, so a stalled consumer
// only holds back the beats addressed to it.
//
// Parameters
//   WIDTH  data width of the input and both outputs (default 4)
//   DEPTH  entries per output FIFO; power of two, at least 2 (default 2)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_data      input beat data
//   in_sel       destination: 0 -> out_1, 1 -> out_2
//   in_valid     input beat present
//   in_ready     beat accepted this cycle (= !rst && !full[in_sel])
//   out_1_data   head of FIFO 1 (don't-care while out_1_valid = 0)
//   out_1_valid  FIFO 1 non-empty
//   out_1_ready  consumer takes the out_1 head
//   out_2_data   head of FIFO 2 (don't-care while out_2_valid = 0)
//   out_2_valid  FIFO 2 non-empty
//   out_2_ready  consumer takes the out_2 head
//   cnt_1        saturating count of beats delivered on out_1
//   cnt_2        saturating count of beats delivered on out_2
//
// Optional feature
//   STREAM_DEMUX_STATS_EN  when defined, adds cnt_1/cnt_2 and their counters.
//                          The datapath is identical either way.
// ---------------------------------------------------------------------------
module stream_demux_1x2 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_1_data,
    output logic             out_1_valid,
    input  logic             out_1_ready,
    output logic [WIDTH-1:0] out_2_data,
    output logic             out_2_valid,
    input  logic             out_2_ready
`ifdef STREAM_DEMUX_STATS_EN
    ,
    output logic [7:0]       cnt_1,
    output logic [7:0]       cnt_2
`endif
);

    localparam int AW = $clog2(DEPTH);

    // One extra MSB distinguishes full from empty when the low bits match.
    typedef logic [AW:0] ptr_t;

    ptr_t wptr_1_q, wptr_1_d, rptr_1_q, rptr_1_d;
    ptr_t wptr_2_q, wptr_2_d, rptr_2_q, rptr_2_d;

    logic [WIDTH-1:0] mem_1_q [DEPTH];
    logic [WIDTH-1:0] mem_2_q [DEPTH];

    logic full_1, full_2;
    logic push_1, push_2;
    logic pop_1, pop_2;

    // -----------------------------------------------------------------------
    // Status and handshakes
    // -----------------------------------------------------------------------
    assign full_1 = (wptr_1_q[AW-1:0] == rptr_1_q[AW-1:0]) &&
                    (wptr_1_q[AW] != rptr_1_q[AW]);
    assign full_2 = (wptr_2_q[AW-1:0] == rptr_2_q[AW-1:0]) &&
                    (wptr_2_q[AW] != rptr_2_q[AW]);

    // Full is judged on registered pointers only: a FIFO that is full stays
    // closed this cycle even if its head is leaving, which keeps the
    // out_k_ready -> in_ready path out of the design.
    assign in_ready = !rst && !(in_sel ? full_2 : full_1);

    assign push_1 = in_valid && in_ready && !in_sel;
    assign push_2 = in_valid && in_ready &&  in_sel;

    assign out_1_valid = (wptr_1_q != rptr_1_q);
    assign out_2_valid = (wptr_2_q != rptr_2_q);

    assign pop_1 = out_1_valid && out_1_ready;
    assign pop_2 = out_2_valid && out_2_ready;

    // First-word fall-through: the head is read straight from storage.
    assign out_1_data = mem_1_q[rptr_1_q[AW-1:0]];
    assign out_2_data = mem_2_q[rptr_2_q[AW-1:0]];

    // -----------------------------------------------------------------------
    // Pointer next-state
    // -----------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path through
    // the block can leave it unassigned and infer a latch.
    always_comb begin
        wptr_1_d = wptr_1_q;
        rptr_1_d = rptr_1_q;
        wptr_2_d = wptr_2_q;
        rptr_2_d = rptr_2_q;

        if (push_1) wptr_1_d = wptr_1_q + 1'b1;
        if (pop_1)  rptr_1_d = rptr_1_q + 1'b1;
        if (push_2) wptr_2_d = wptr_2_q + 1'b1;
        if (pop_2)  rptr_2_d = rptr_2_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_1_q <= '0;
            rptr_1_q <= '0;
            wptr_2_q <= '0;
            rptr_2_q <= '0;
        end else begin
            wptr_1_q <= wptr_1_d;
            rptr_1_q <= rptr_1_d;
            wptr_2_q <= wptr_2_d;
            rptr_2_q <= rptr_2_d;
        end
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    // NOTE: storage is deliberately not reset; clearing the pointers already
    // makes every entry unreachable, and a reset-free array maps onto plain
    // RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push_1) mem_1_q[wptr_1_q[AW-1:0]] <= in_data;
        if (push_2) mem_2_q[wptr_2_q[AW-1:0]] <= in_data;
    end

`ifdef STREAM_DEMUX_STATS_EN
    // -----------------------------------------------------------------------
    // Delivery counters, saturating at 255
    // -----------------------------------------------------------------------
    logic [7:0] cnt_1_q, cnt_1_d;
    logic [7:0] cnt_2_q, cnt_2_d;

    always_comb begin
        cnt_1_d = cnt_1_q;
        cnt_2_d = cnt_2_q;
        if (pop_1 && (cnt_1_q != 8'hFF)) cnt_1_d = cnt_1_q + 8'd1;
        if (pop_2 && (cnt_2_q != 8'hFF)) cnt_2_d = cnt_2_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_1_q <= '0;
            cnt_2_q <= '0;
        end else begin
            cnt_1_q <= cnt_1_d;
            cnt_2_q <= cnt_2_d;
        end
    end

    assign cnt_1 = cnt_1_q;
    assign cnt_2 = cnt_2_q;
`endif

endmodule
